// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
//   Watches the active-low segment/anode bus of a multiplexed 4-digit
//   seven-segment driver and rebuilds the 16-bit hex value on display.
//   Each digit must hold a stable one-hot-low anode/segment pair for
//   SETTLE_CYCLES samples before it is captured. A frame completes when all
//   four digits have been captured. A timeout flags a driver that stopped
//   scanning.
//
// Ports
//   clk         system clock (same clock as the display driver)
//   rst_n       synchronous, active-low reset
//   seg[6:0]    segment lines, active-low, seg[0]=a .. seg[6]=g
//   an[3:0]     anode enables, active-low, an[0] = rightmost digit
//   value       last complete frame, value[4k+3:4k] = digit k
//   frame_valid one-cycle pulse when value/frame_err/blank_mask update
//   frame_err   last frame held at least one undecodable pattern
//   blank_mask  bit k set if digit k was blank in the last frame
//   digit_err   one-cycle pulse on capture of an undecodable pattern
//   timeout     no capture for TIMEOUT_CYCLES cycles
module sevenseg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  blank_mask,
  output logic        digit_err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0]       SETTLE_N = 8'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_N    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_ONE  = CNT_W'(1);

  // Segment pattern -> {err, blank, nibble}. Blank and error both store 0.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b1000000: r = {2'b00, 4'h0};
      7'b1111001: r = {2'b00, 4'h1};
      7'b0100100: r = {2'b00, 4'h2};
      7'b0110000: r = {2'b00, 4'h3};
      7'b0011001: r = {2'b00, 4'h4};
      7'b0010010: r = {2'b00, 4'h5};
      7'b0000010: r = {2'b00, 4'h6};
      7'b1111000: r = {2'b00, 4'h7};
      7'b0000000: r = {2'b00, 4'h8};
      7'b0010000: r = {2'b00, 4'h9};
      7'b0001000: r = {2'b00, 4'hA};
      7'b0000011: r = {2'b00, 4'hB};
      7'b1000110: r = {2'b00, 4'hC};
      7'b0100001: r = {2'b00, 4'hD};
      7'b0000110: r = {2'b00, 4'hE};
      7'b0001110: r = {2'b00, 4'hF};
      7'b1111111: r = {2'b01, 4'h0};
      default:    r = {2'b10, 4'h0};
    endcase
    return r;
  endfunction

  // Anode lines -> {one_hot_low, digit_index}.
  function automatic logic [2:0] decode_an(input logic [3:0] a);
    logic [2:0] r;
    case (a)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  logic [6:0]       seg_r, prev_seg_r;
  logic [3:0]       an_r, prev_an_r;
  state_t           state_r;
  logic [7:0]       stable_cnt_r;
  logic [3:0]       mask_r;
  logic [15:0]      shadow_val_r;
  logic [3:0]       shadow_blank_r;
  logic             shadow_err_r;
  logic [CNT_W-1:0] tmo_cnt_r;

  logic [2:0]       an_dec_s;
  logic             onehot_s;
  logic [1:0]       idx_s;
  logic             changed_s;
  logic [5:0]       dec_s;
  logic [7:0]       cnt_inc_s;
  logic             frame_done_s;
  logic [CNT_W-1:0] tmo_next_s;
  logic             tmo_hit_s;
  logic             capture_s;
  logic [3:0]       mask_base_s;
  logic             err_base_s;

  // Decisions derived from the sample register and the previous sample.
  always_comb begin
    an_dec_s     = decode_an(an_r);
    onehot_s     = an_dec_s[2];
    idx_s        = an_dec_s[1:0];
    changed_s    = ({an_r, seg_r} != {prev_an_r, prev_seg_r});
    dec_s        = decode_seg(seg_r);
    cnt_inc_s    = stable_cnt_r + 8'd1;
    frame_done_s = (mask_r == 4'b1111);
    // Completion empties the mask/error before this cycle's capture merges in,
    // so a capture coinciding with completion seeds the next frame.
    mask_base_s  = frame_done_s ? 4'b0000 : mask_r;
    err_base_s   = frame_done_s ? 1'b0 : shadow_err_r;
    tmo_next_s   = (tmo_cnt_r == TMO_N) ? TMO_N : (tmo_cnt_r + TMO_ONE);
    tmo_hit_s    = (tmo_next_s == TMO_N);
  end

  // Capture strobe: fires on the cycle the stable count reaches SETTLE_N.
  // A fresh one-hot sample counts as 1, so SETTLE_N==1 captures at once.
  always_comb begin
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (onehot_s) capture_s = (SETTLE_N == 8'd1);
        else          capture_s = 1'b0;
      end
      SETTLE: begin
        if (changed_s) capture_s = onehot_s && (SETTLE_N == 8'd1);
        else           capture_s = onehot_s && (cnt_inc_s == SETTLE_N);
      end
      HOLD: begin
        if (changed_s) capture_s = onehot_s && (SETTLE_N == 8'd1);
        else           capture_s = 1'b0;
      end
      default: capture_s = 1'b0;
    endcase
  end

  // Dwell tracking FSM: IDLE (no single digit), SETTLE (counting), HOLD (captured).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      stable_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (onehot_s) begin
            stable_cnt_r <= 8'd1;
            state_r      <= capture_s ? HOLD : SETTLE;
          end else begin
            stable_cnt_r <= 8'd0;
          end
        end
        SETTLE, HOLD: begin
          if (changed_s) begin
            if (onehot_s) begin
              stable_cnt_r <= 8'd1;
              state_r      <= capture_s ? HOLD : SETTLE;
            end else begin
              stable_cnt_r <= 8'd0;
              state_r      <= IDLE;
            end
          end else if (state_r == SETTLE) begin
            stable_cnt_r <= cnt_inc_s;
            if (capture_s) state_r <= HOLD;
          end
        end
        default: begin
          state_r      <= IDLE;
          stable_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Input sampling, shadow capture, frame completion and timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r          <= 7'd0;
      an_r           <= 4'd0;
      prev_seg_r     <= 7'd0;
      prev_an_r      <= 4'd0;
      mask_r         <= 4'd0;
      shadow_val_r   <= 16'd0;
      shadow_blank_r <= 4'd0;
      shadow_err_r   <= 1'b0;
      tmo_cnt_r      <= '0;
      value          <= 16'd0;
      frame_valid    <= 1'b0;
      frame_err      <= 1'b0;
      blank_mask     <= 4'd0;
      digit_err      <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      seg_r      <= seg;
      an_r       <= an;
      prev_seg_r <= seg_r;
      prev_an_r  <= an_r;

      frame_valid <= frame_done_s;
      if (frame_done_s) begin
        value      <= shadow_val_r;
        blank_mask <= shadow_blank_r;
        frame_err  <= shadow_err_r;
      end

      digit_err <= capture_s && dec_s[5];

      if (capture_s) begin
        shadow_val_r[{idx_s, 2'b00} +: 4] <= dec_s[3:0];
        shadow_blank_r[idx_s]             <= dec_s[4];
        shadow_err_r                      <= err_base_s | dec_s[5];
        mask_r                            <= mask_base_s | (4'b0001 << idx_s);
        tmo_cnt_r                         <= '0;
        timeout                           <= 1'b0;
      end else begin
        shadow_err_r <= err_base_s;
        tmo_cnt_r    <= tmo_next_s;
        if (tmo_hit_s) begin
          // A stalled scan abandons the partial frame; value is kept.
          timeout <= 1'b1;
          mask_r  <= 4'b0000;
        end else begin
          mask_r  <= mask_base_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
module tb_sevenseg_scan_decoder;

  localparam int SETTLE = 2;
  localparam int TMO    = 64;
  localparam int CW     = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        frame_valid, frame_err, digit_err, timeout;
  logic [3:0]  blank_mask;

  sevenseg_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .an         (an),
    .value      (value),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .blank_mask (blank_mask),
    .digit_err  (digit_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fv_cnt, de_cnt;
  logic [15:0] first_fv_val, last_fv_val;

  // Reference model state: run-length of identical samples plus frame bookkeeping.
  logic [10:0] m_samp, m_prev;
  int          m_runlen;
  logic [3:0]  m_mask, m_shb, m_bm;
  logic [3:0]  m_sh [4];
  logic        m_she, m_fv, m_fe, m_de, m_to;
  logic [15:0] m_value;
  int          m_tcnt;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // 0..15 = hex digit, 16 = blank, 17 = undecodable
  function automatic int tb_decode(input logic [6:0] s);
    int r;
    r = 17;
    if (s == 7'b1111111) r = 16;
    for (int d = 0; d < 16; d++) if (seg_of(d) == s) r = d;
    return r;
  endfunction

  function automatic logic [3:0] digit_an(input int k);
    logic [3:0] r;
    r = 4'b1111;
    r[k] = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_samp = 11'd0; m_prev = 11'd0; m_runlen = 0;
    m_mask = 4'd0; m_shb = 4'd0; m_she = 1'b0; m_bm = 4'd0;
    for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
    m_fv = 1'b0; m_fe = 1'b0; m_de = 1'b0; m_to = 1'b0;
    m_value = 16'd0; m_tcnt = 0;
  endtask

  // One clock of the reference: a digit is captured when its one-hot sample
  // has been seen SETTLE times in a row; a full mask publishes next cycle.
  task automatic model_update();
    logic [3:0] a;
    bit cap;
    int k, d;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_samp != m_prev) m_runlen = 1;
      else if (m_runlen < 1000000) m_runlen++;
      a = m_samp[10:7];
      cap = ($countones(~a) == 1) && (m_runlen == SETTLE);
      m_fv = (m_mask == 4'hF);
      m_de = 1'b0;
      if (m_fv) begin
        m_value = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
        m_bm = m_shb; m_fe = m_she;
        m_mask = 4'd0; m_she = 1'b0;
      end
      if (cap) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) k = i;
        d = tb_decode(m_samp[6:0]);
        m_sh[k]  = (d < 16) ? 4'(d) : 4'd0;
        m_shb[k] = (d == 16);
        m_de     = (d == 17);
        m_she    = m_she | m_de;
        m_mask[k] = 1'b1;
        m_tcnt = 0; m_to = 1'b0;
      end else begin
        if (m_tcnt < TMO) m_tcnt++;
        if (m_tcnt == TMO) begin
          m_to = 1'b1; m_mask = 4'd0;
        end
      end
      m_prev = m_samp;
      m_samp = {an, seg};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("cycle", {8'h00, value, frame_valid, frame_err, blank_mask, digit_err, timeout},
                   {8'h00, m_value, m_fv, m_fe, m_bm, m_de, m_to});
    if (frame_valid === 1'b1) begin
      if (fv_cnt == 0) first_fv_val = value;
      fv_cnt++;
      last_fv_val = value;
    end
    if (digit_err === 1'b1) de_cnt++;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    repeat (n) step();
  endtask

  initial begin
    int to_first, off, k, n;
    logic [6:0] s;
    model_reset();
    fv_cnt = 0; de_cnt = 0; first_fv_val = 16'd0; last_fv_val = 16'd0;
    rst_n = 1'b0; an = 4'b1111; seg = 7'b1111111;
    @(negedge clk);
    repeat (3) step();
    check("reset_outputs", {8'h00, value, frame_valid, frame_err, blank_mask, digit_err, timeout}, 32'd0);
    rst_n = 1'b1;

    // 1: plain scan of 4,3,2,1
    dwell(4'b1110, seg_of(4), 8);
    dwell(4'b1101, seg_of(3), 8);
    dwell(4'b1011, seg_of(2), 8);
    an = 4'b0111; seg = seg_of(1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("t1_fv_timing", frame_valid, (i == 4));
      if (i == 4) begin
        check("t1_value", value, 16'h1234);
        check("t1_err_blank", {frame_err, blank_mask}, 5'd0);
      end
    end
    check("t1_fv_count", fv_cnt, 1);

    // 2: one-cycle glitch on digit 1 inside a digit-0 dwell
    fv_cnt = 0;
    dwell(4'b1101, seg_of(7), 8);
    dwell(4'b1110, seg_of(5), 4);
    dwell(4'b1101, 7'b0000000, 1);
    dwell(4'b1110, seg_of(5), 4);
    dwell(4'b1011, seg_of(6), 8);
    dwell(4'b0111, seg_of(9), 8);
    check("t2_fv_count", fv_cnt, 1);
    check("t2_value", last_fv_val, 16'h9675);

    // 3: blank digit 2, undecodable digit 3
    fv_cnt = 0; de_cnt = 0;
    dwell(4'b1110, seg_of(1), 6);
    dwell(4'b1101, seg_of(2), 6);
    dwell(4'b1011, 7'b1111111, 6);
    check("t3_no_err_yet", de_cnt, 0);
    dwell(4'b0111, 7'b0101010, 6);
    check("t3_digit_err", de_cnt, 1);
    check("t3_value", last_fv_val, 16'h0021);
    check("t3_blank", blank_mask, 4'b0100);
    check("t3_frame_err", frame_err, 1'b1);

    // 4: partial frame, then stalled scan -> timeout drops the partial digits
    dwell(4'b1110, seg_of(3), 6);
    dwell(4'b1101, seg_of(4), 6);   // capture on step 3 of this dwell
    an = 4'b1111; seg = 7'b1111111;
    to_first = 0;
    for (int j = 1; j <= 70; j++) begin
      step();
      if (timeout === 1'b1 && to_first == 0) to_first = j;
    end
    check("t4_timeout_cycle", to_first, 61);
    check("t4_value_kept", value, 16'h0021);
    fv_cnt = 0;
    dwell(4'b1011, seg_of(5), 6);
    check("t4_timeout_clear", timeout, 1'b0);
    dwell(4'b0111, seg_of(6), 6);
    check("t4_no_early_frame", fv_cnt, 0);
    dwell(4'b1110, seg_of(7), 6);
    dwell(4'b1101, seg_of(8), 6);
    check("t4_fv_count", fv_cnt, 1);
    check("t4_value", last_fv_val, 16'h6587);

    // 5: reset mid-frame discards partial digits
    dwell(4'b1110, seg_of(1), 6);
    dwell(4'b1101, seg_of(2), 6);
    dwell(4'b1011, seg_of(3), 6);
    rst_n = 1'b0; an = 4'b1111; seg = 7'b1111111;
    for (int j = 0; j < 3; j++) begin
      step();
      check("t5_reset_outputs", {8'h00, value, frame_valid, frame_err, blank_mask, digit_err, timeout}, 32'd0);
    end
    rst_n = 1'b1;
    fv_cnt = 0;
    dwell(4'b0111, seg_of(13), 6);
    dwell(4'b1110, seg_of(10), 6);
    dwell(4'b1101, seg_of(11), 6);
    dwell(4'b1011, seg_of(12), 6);
    check("t5_fv_count", fv_cnt, 1);
    check("t5_first_value", first_fv_val, 16'hDCBA);

    // 6: two anodes low must never capture
    fv_cnt = 0; de_cnt = 0;
    dwell(4'b1100, 7'b0101010, 10);
    check("t6_no_capture", de_cnt, 0);
    dwell(4'b1110, seg_of(1), 6);
    dwell(4'b1101, seg_of(0), 6);
    dwell(4'b1011, seg_of(15), 6);
    dwell(4'b0111, seg_of(14), 6);
    check("t6_fv_count", fv_cnt, 1);
    check("t6_value", last_fv_val, 16'hEF01);
    check("t6_frame_err", frame_err, 1'b0);

    // Randomized scans with random dwells, stray patterns and anode noise
    for (int f = 0; f < 12; f++) begin
      off = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        k = (off + i) % 4;
        s = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_of($urandom_range(0, 15));
        n = $urandom_range(1, 6);
        dwell(digit_an(k), s, n);
        if ($urandom_range(0, 5) == 0) dwell(4'($urandom), 7'($urandom), $urandom_range(1, 3));
      end
    end
    dwell(4'b1111, 7'b1111111, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
